// File: rtl/mem_responder.sv
// mem_responder: 32x8 memory responder with write tracking and error flags; MEM_STATS_EN adds saturating access counters
module mem_responder #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] written_q, written_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic rd_valid_q, rd_valid_d, err_q, err_d;
  logic [1:0] err_code_q, err_code_d;
  logic wr_acc, rd_acc, coll, rd_unw;
  always_comb begin
    wr_acc = state_q == IDLE && write && !read;
    rd_acc = state_q == IDLE && read && !write;
    coll = state_q == IDLE && read && write;
    rd_unw = rd_acc && !written_q[addr];
    state_d = (read || write) ? HOLD : IDLE;
    written_d = written_q | (wr_acc ? DEPTH'(1) << addr : '0);
    data_out_d = rd_acc ? (written_q[addr] ? mem[addr] : '0) : data_out_q;
    rd_valid_d = rd_acc;
    err_d = coll || rd_unw;
    err_code_d = coll ? 2'b01 : rd_unw ? 2'b10 : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      written_q <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q <= state_d;
      written_q <= written_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      err_q <= err_d;
      err_code_q <= err_code_d;
    end
  end
  always_ff @(posedge clk) if (!rst && wr_acc) mem[addr] <= data_in;
  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign err = err_q;
  assign err_code = err_code_q;
`ifdef MEM_STATS_EN
  logic [15:0] wr_count_q, wr_count_d, rd_count_q, rd_count_d;
  always_comb begin
    wr_count_d = wr_count_q + {15'b0, wr_acc && wr_count_q != 16'hFFFF};
    rd_count_d = rd_count_q + {15'b0, rd_acc && rd_count_q != 16'hFFFF};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end
  assign wr_count = wr_count_q;
  assign rd_count = rd_count_q;
`else
  assign wr_count = 16'h0000;
  assign rd_count = 16'h0000;
`endif
endmodule
